// File: rtl/fifo_word_reader.sv
// rtl/fifo_word_reader.sv - packs bytes from a byte FIFO into 32-bit words, with flush of partial words
module fifo_word_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_pend;
    logic        r_flush_req;
    logic        r_run;
    logic [31:0] r_asm;
    logic [2:0]  r_out_bytes;

    logic [2:0]  w_sum;
    logic        w_xfer;
    logic        w_clear;
    logic        w_flush_nxt;
    logic [2:0]  w_out_bytes_nxt;

    // Byte count once the outstanding read (if any) lands at the coming edge.
    assign w_sum = r_cnt + {2'b00, r_pend};

    // r_run holds reads off until the first clock edge after reset release.
    assign fifo_rd_en = r_run && (r_state == S_FILL) && !fifo_empty
                        && !r_flush_req && (w_sum < 3'd4);

    assign out_valid = (r_state == S_OUT);
    assign out_data  = out_valid ? r_asm : 32'd0;
    assign out_bytes = r_out_bytes;
    assign busy      = (r_cnt != 3'd0) || r_pend || r_flush_req || out_valid;
    assign w_xfer    = out_valid && out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_nxt     = r_flush_req;
        w_out_bytes_nxt = r_out_bytes;
        w_clear         = 1'b0;
        case (r_state)
            S_FILL: begin
                if (flush) begin
                    w_flush_nxt = 1'b1;
                end
                // A full word always goes out first; a pending flush survives it.
                if (w_sum == 3'd4) begin
                    w_state_nxt     = S_OUT;
                    w_out_bytes_nxt = 3'd4;
                end else if (r_flush_req) begin
                    if (r_pend) begin
                        w_state_nxt = S_DRAIN;
                    end else if (r_cnt != 3'd0) begin
                        w_state_nxt     = S_OUT;
                        w_out_bytes_nxt = r_cnt;
                    end else if (!flush) begin
                        w_flush_nxt = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                w_state_nxt     = S_OUT;
                w_out_bytes_nxt = w_sum;
            end
            S_OUT: begin
                if (w_xfer) begin
                    w_state_nxt     = S_FILL;
                    w_clear         = 1'b1;
                    w_out_bytes_nxt = 3'd0;
                    if (r_out_bytes != 3'd4) begin
                        w_flush_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FILL;
            r_cnt       <= 3'd0;
            r_pend      <= 1'b0;
            r_flush_req <= 1'b0;
            r_run       <= 1'b0;
            r_asm       <= 32'd0;
            r_out_bytes <= 3'd0;
        end else begin
            r_run       <= 1'b1;
            r_state     <= w_state_nxt;
            r_flush_req <= w_flush_nxt;
            r_out_bytes <= w_out_bytes_nxt;
            r_pend      <= fifo_rd_en;
            if (w_clear) begin
                r_cnt <= 3'd0;
                r_asm <= 32'd0;
            end else if (r_pend) begin
                r_cnt                            <= r_cnt + 3'd1;
                r_asm[{r_cnt[1:0], 3'b000} +: 8] <= fifo_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_reader.sv
// tb/tb_fifo_word_reader.sv - directed self-checking bench for fifo_word_reader
module tb_fifo_word_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        busy;

    logic [7:0]  mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          pops0;

    fifo_word_reader dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_bytes    (out_bytes),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Byte FIFO model: data appears one cycle after an accepted read.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_bytes", {29'd0, out_bytes}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        @(negedge clk);
        chk("rst_rden_nonempty", {31'd0, fifo_rd_en}, 32'd0);

        // Four back-to-back reads, one full word
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rel_rden", {31'd0, fifo_rd_en}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_rden", {31'd0, fifo_rd_en}, 32'd1);
        end
        @(negedge clk);
        chk("t1_rden_off", {31'd0, fifo_rd_en}, 32'd0);
        wait_valid("t1", 10);
        chk("t1_data", out_data, 32'h44332211);
        chk("t1_bytes", {29'd0, out_bytes}, 32'd4);
        @(negedge clk);
        chk("t1_done_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_done_busy", {31'd0, busy}, 32'd0);

        // Backpressure holds the word and stops reads
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(i[7:0]);
        wait_valid("t2", 20);
        chk("t2_data", out_data, 32'h04030201);
        chk("t2_bytes", {29'd0, out_bytes}, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_data", out_data, 32'h04030201);
            chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_hold_rden", {31'd0, fifo_rd_en}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        wait_valid("t2b", 20);
        chk("t2b_data", out_data, 32'h08070605);
        chk("t2b_bytes", {29'd0, out_bytes}, 32'd4);
        @(negedge clk);

        // Stall on empty, then flush a 2-byte partial
        out_ready = 1'b0;
        push(8'hAA); push(8'hBB);
        repeat (6) @(negedge clk);
        chk("t3_stall_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_stall_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("t3", 10);
        chk("t3_data", out_data, 32'h0000BBAA);
        chk("t3_bytes", {29'd0, out_bytes}, 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_busy_after", {31'd0, busy}, 32'd0);
        chk("t3_valid_after", {31'd0, out_valid}, 32'd0);

        // Flush during the second accepted read drains exactly one more byte
        pops0 = rd_ptr;
        push(8'hC1); push(8'hC2); push(8'hC3);
        @(negedge clk);
        chk("t4_rd2", {31'd0, fifo_rd_en}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_no_rd3", {31'd0, fifo_rd_en}, 32'd0);
        wait_valid("t4", 10);
        chk("t4_data", out_data, 32'h0000C2C1);
        chk("t4_bytes", {29'd0, out_bytes}, 32'd2);
        chk("t4_reads", rd_ptr - pops0, 32'd2);
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("t4_c3_hold", {31'd0, out_valid}, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("t4b", 10);
        chk("t4b_data", out_data, 32'h000000C3);
        chk("t4b_bytes", {29'd0, out_bytes}, 32'd1);
        @(negedge clk);

        // Flush with nothing assembled produces no word
        chk("t5_idle_busy", {31'd0, busy}, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_busy_req", {31'd0, busy}, 32'd1);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t5_busy_clr", {31'd0, busy}, 32'd0);
        chk("t5_valid2", {31'd0, out_valid}, 32'd0);

        // Flush in the cycle the word completes applies after the full word
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("t6", 10);
        chk("t6_data", out_data, 32'hD4D3D2D1);
        chk("t6_bytes", {29'd0, out_bytes}, 32'd4);
        @(negedge clk);
        chk("t6_req_busy", {31'd0, busy}, 32'd1);
        chk("t6_req_valid", {31'd0, out_valid}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t6_d5_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_d5_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("t6b", 10);
        chk("t6b_data", out_data, 32'h000000D5);
        chk("t6b_bytes", {29'd0, out_bytes}, 32'd1);
        @(negedge clk);

        // Asynchronous reset with three bytes held and one read outstanding
        out_ready = 1'b0;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        repeat (4) @(negedge clk);
        chk("t7_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_data", out_data, 32'd0);
        chk("t7_rst_bytes", {29'd0, out_bytes}, 32'd0);
        chk("t7_rst_busy", {31'd0, busy}, 32'd0);
        chk("t7_rst_rden", {31'd0, fifo_rd_en}, 32'd0);
        push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        wait_valid("t7", 20);
        chk("t7_data", out_data, 32'hF4F3F2F1);
        chk("t7_bytes", {29'd0, out_bytes}, 32'd4);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
